config_sequencer: RTL and testbench

Streams a fabric bitstream into the tile configuration bus. Accepts 32-bit words over a valid/ready handshake as (address, data) pairs and drives the shared `config_addr`/`config_data` bus, one registered write per pair. The bus is broadcast to every PE tile, where per-tile decode raises the switch-box, CB0, CB1 or CLB enable. Sits between the off-chip loader and the tile array, one instance per fabric.

---
 rtl/config_sequencer_pkg.sv | 24 ++
 rtl/config_sequencer.sv | 124 ++++++++++++
 tb/tb_config_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_sequencer_pkg.sv
// Shared configuration-bus constants. Tile decode uses the same block types and idle address.
package config_sequencer_pkg;

   localparam logic [15:0] CONFIG_SB  = 16'd7;
   localparam logic [15:0] CONFIG_CB0 = 16'd6;
   localparam logic [15:0] CONFIG_CB1 = 16'd5;
   localparam logic [15:0] CONFIG_CLB = 16'd4;

   // Block type 0xFFFF never decodes in a tile, so this address leaves every tile untouched.
   localparam logic [31:0] CFG_IDLE_ADDR = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_ADDR  = 2'd0,
      S_DATA  = 2'd1,
      S_WRITE = 2'd2,
      S_GAP   = 2'd3
   } seq_state_t;

   function automatic logic block_valid(input logic [15:0] block_type);
      return (block_type == CONFIG_SB)  || (block_type == CONFIG_CB0) ||
             (block_type == CONFIG_CB1) || (block_type == CONFIG_CLB);
   endfunction

endpackage

// File: rtl/config_sequencer.sv
// config_sequencer: turns an (address, data) word stream into one registered config bus write per pair.
// Latency: bus valid the cycle after the data word is accepted, then GAP_CYCLES idle cycles.
// Backpressure: in_ready is low during the write and gap cycles, decoded from state alone.
module config_sequencer
   import config_sequencer_pkg::*;
#(
   parameter int GAP_CYCLES = 0,
   parameter int COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   input  logic               in_last,
   output logic [31:0]        config_addr,
   output logic [31:0]        config_data,
   output logic               config_busy,
   output logic               config_done,
   output logic [COUNT_W-1:0] write_count,
   output logic               error
);

   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_INIT = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   seq_state_t       state;
   seq_state_t       state_nxt;
   logic [31:0]      pend_addr;
   logic             last_q;
   logic [GAP_W-1:0] gap_cnt;

   logic addr_hs;
   logic data_hs;
   logic write_end;
   logic stream_end;

   assign addr_hs    = in_valid && (state == S_ADDR);
   assign data_hs    = in_valid && (state == S_DATA);
   // Leaving the write/gap phase for the next address word.
   assign write_end  = ((state == S_WRITE) || (state == S_GAP)) && (state_nxt == S_ADDR);
   assign stream_end = write_end && last_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_ADDR;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_ADDR:  if (in_valid && !in_last) state_nxt = S_DATA;
         S_DATA:  if (in_valid) state_nxt = S_WRITE;
         S_WRITE: state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_ADDR;
         S_GAP:   if (gap_cnt == '0) state_nxt = S_ADDR;
         default: state_nxt = S_ADDR;
      endcase
   end

   always_comb begin
      in_ready = (state == S_ADDR) || (state == S_DATA);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_addr   <= '0;
         last_q      <= 1'b0;
         gap_cnt     <= '0;
         config_addr <= CFG_IDLE_ADDR;
         config_data <= '0;
         config_busy <= 1'b0;
         config_done <= 1'b0;
         write_count <= '0;
         error       <= 1'b0;
      end else begin
         config_done <= 1'b0;

         if (addr_hs) begin
            if (!config_busy) begin
               write_count <= '0;
            end
            if (in_last) begin
               // An address word can never end a stream cleanly: drop it and close the stream.
               error       <= 1'b1;
               config_done <= 1'b1;
               config_busy <= 1'b0;
            end else begin
               pend_addr   <= in_data;
               config_busy <= 1'b1;
            end
         end

         if (data_hs) begin
            last_q <= in_last;
            if (block_valid(pend_addr[31:16])) begin
               config_addr <= pend_addr;
               config_data <= in_data;
               if (write_count != '1) begin
                  write_count <= write_count + COUNT_W'(1);
               end
            end else begin
               error <= 1'b1;
            end
         end

         if (state == S_WRITE) begin
            config_addr <= CFG_IDLE_ADDR;
            config_data <= '0;
            gap_cnt     <= GAP_INIT;
         end else if ((state == S_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end

         if (stream_end) begin
            config_done <= 1'b1;
            config_busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_config_sequencer.sv
// Directed and randomized streams checked against a timing/scoreboard model of the config bus.
module tb_config_sequencer;

   localparam int GAP = 2;
   localparam int CW  = 16;
   localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

   logic          clk      = 1'b0;
   logic          reset    = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data  = 32'h0;
   logic          in_last  = 1'b0;
   logic [31:0]   config_addr;
   logic [31:0]   config_data;
   logic          config_busy;
   logic          config_done;
   logic [CW-1:0] write_count;
   logic          error;

   typedef struct {
      int          cyc;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         bus_q[$];
   int          done_q[$];
   logic        done_busy_q[$];
   logic [31:0] stim_addr[$];
   logic [31:0] stim_data[$];
   int          stim_stall[$];
   int          stim_dstall[$];

   int   cyc     = 0;
   int   tests   = 0;
   int   fails   = 0;
   logic exp_err = 1'b0;
   int   a_hs;
   int   d_hs;

   config_sequencer #(.GAP_CYCLES(GAP), .COUNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .config_addr (config_addr),
      .config_data (config_data),
      .config_busy (config_busy),
      .config_done (config_done),
      .write_count (write_count),
      .error       (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus and done monitor: any non-idle bus cycle is a write.
   always @(negedge clk) begin
      if (config_addr !== IDLE || config_data !== 32'h0) begin
         bus_q.push_back('{cyc, config_addr, config_data});
      end
      if (config_done === 1'b1) begin
         done_q.push_back(cyc);
         done_busy_q.push_back(config_busy);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic legal(input logic [31:0] a);
      return (a[31:16] >= 16'd4) && (a[31:16] <= 16'd7);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset   = 1'b1;
      exp_err = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send_word(input logic [31:0] d, input logic l, output int hs);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (in_ready !== 1'b1 && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 64) begin
         tests++;
         fails++;
         $error("FAIL ready_timeout: observed in_ready low for %0d cycles, required at most 63", guard);
      end
      hs = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom();
      in_last  = 1'($urandom());
   endtask

   task automatic add_pair(input logic [31:0] a, input logic [31:0] d, input int s, input int ds);
      stim_addr.push_back(a);
      stim_data.push_back(d);
      stim_stall.push_back(s);
      stim_dstall.push_back(ds);
   endtask

   task automatic run_stream(input string tag);
      int  n, ah, dh, prev_d, exp_cnt, m, exp_a;
      wr_t exp_q[$];
      n       = stim_addr.size();
      prev_d  = 0;
      exp_cnt = 0;
      bus_q.delete();
      done_q.delete();
      done_busy_q.delete();
      for (int i = 0; i < n; i++) begin
         repeat (stim_stall[i]) @(negedge clk);
         send_word(stim_addr[i], 1'b0, ah);
         if (i > 0) begin
            // Earliest acceptance is GAP+2 cycles after the previous data word.
            exp_a = (stim_stall[i] + 1 > GAP + 2) ? prev_d + 1 + stim_stall[i] : prev_d + 2 + GAP;
            check({tag, "_addr_accept"}, ah, exp_a);
         end
         repeat (stim_dstall[i]) @(negedge clk);
         send_word(stim_data[i], i == n - 1, dh);
         check({tag, "_data_accept"}, dh, ah + 1 + stim_dstall[i]);
         if (legal(stim_addr[i])) begin
            exp_q.push_back('{dh + 1, stim_addr[i], stim_data[i]});
            exp_cnt++;
         end else begin
            exp_err = 1'b1;
         end
         prev_d = dh;
      end
      repeat (GAP + 4) @(negedge clk);
      check({tag, "_n_writes"}, bus_q.size(), exp_q.size());
      m = (bus_q.size() < exp_q.size()) ? bus_q.size() : exp_q.size();
      for (int k = 0; k < m; k++) begin
         check({tag, "_wr_cycle"}, bus_q[k].cyc, exp_q[k].cyc);
         check({tag, "_wr_addr"}, bus_q[k].addr, exp_q[k].addr);
         check({tag, "_wr_data"}, bus_q[k].data, exp_q[k].data);
      end
      check({tag, "_n_done"}, done_q.size(), 1);
      if (done_q.size() > 0) begin
         check({tag, "_done_cycle"}, done_q[0], prev_d + 2 + GAP);
         check({tag, "_busy_at_done"}, done_busy_q[0], 1'b0);
      end
      check({tag, "_write_count"}, write_count, exp_cnt);
      check({tag, "_error"}, error, exp_err);
      check({tag, "_busy_after"}, config_busy, 1'b0);
      stim_addr.delete();
      stim_data.delete();
      stim_stall.delete();
      stim_dstall.delete();
   endtask

   task automatic rand_streams(input int count);
      int          n;
      logic [15:0] bt;
      for (int s = 0; s < count; s++) begin
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 0) begin
               bt = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(8, 300));
            end else begin
               bt = 16'($urandom_range(4, 7));
            end
            add_pair({bt, 16'($urandom())}, $urandom(), $urandom_range(0, 4), $urandom_range(0, 2));
         end
         run_stream("rand");
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_addr", config_addr, IDLE);
      check("rst_data", config_data, 32'h0);
      check("rst_busy", config_busy, 1'b0);
      check("rst_done", config_done, 1'b0);
      check("rst_count", write_count, 0);
      check("rst_error", error, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready", in_ready, 1'b1);

      // Single SB write
      add_pair(32'h0007_0003, 32'h0000_0015, 0, 0);
      run_stream("single");

      // Four back-to-back pairs to tile 1
      add_pair(32'h0007_0001, 32'h1111_0001, 0, 0);
      add_pair(32'h0006_0001, 32'h2222_0002, 0, 0);
      add_pair(32'h0005_0001, 32'h3333_0003, 0, 0);
      add_pair(32'h0004_0001, 32'h4444_0004, 0, 0);
      run_stream("b2b");

      // Bad block type mid-stream
      add_pair(32'h0004_0001, 32'h0000_00A1, 0, 0);
      add_pair(32'h0009_0001, 32'h0000_00B2, 0, 0);
      add_pair(32'h0007_0001, 32'h0000_00C3, 0, 0);
      run_stream("badtype");

      rand_streams(8);

      // in_last on an address word
      apply_reset();
      bus_q.delete();
      done_q.delete();
      done_busy_q.delete();
      send_word(32'h0007_0002, 1'b1, a_hs);
      repeat (GAP + 4) @(negedge clk);
      check("addrlast_n_done", done_q.size(), 1);
      if (done_q.size() > 0) check("addrlast_done_cycle", done_q[0], a_hs + 1);
      check("addrlast_bus_idle", bus_q.size(), 0);
      check("addrlast_error", error, 1'b1);
      check("addrlast_count", write_count, 0);
      check("addrlast_busy", config_busy, 1'b0);
      check("addrlast_ready", in_ready, 1'b1);

      // Loader stalls between address and data
      apply_reset();
      add_pair(32'h0005_0009, 32'h1234_5678, 0, 10);
      run_stream("stall");

      // Reset while the write is on the bus
      apply_reset();
      send_word(32'h0006_0002, 1'b0, a_hs);
      send_word(32'h0000_00AB, 1'b1, d_hs);
      check("rstw_pre_addr", config_addr, 32'h0006_0002);
      reset = 1'b0;
      #1;
      check("rstw_addr", config_addr, IDLE);
      check("rstw_data", config_data, 32'h0);
      check("rstw_busy", config_busy, 1'b0);
      check("rstw_count", write_count, 0);
      @(negedge clk);
      reset = 1'b1;
      bus_q.delete();
      done_q.delete();
      repeat (GAP + 4) @(negedge clk);
      check("rstw_no_done", done_q.size(), 0);
      check("rstw_bus_idle", bus_q.size(), 0);
      check("rstw_error", error, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
